// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
  parameter int LAST_OP = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [3:0] req_op0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  input  logic [3:0] req_op1,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_out,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LAST = 4'(LAST_OP);
  logic [1:0] state;
  logic       last_grant;
  logic       id;
  logic       gnt;
  // pick the requester not served last on a tie; handshakes only exist in IDLE/RESP
  always_comb begin
    gnt       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    req_ready = (rst_n && state == IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = (state == RESP) ? (id ? 2'b10 : 2'b01) : 2'b00;
  end
  // grant/latch in IDLE, capture ALU result in EXEC, wait for owner's handshake in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else if (state == IDLE) begin
      if (|req_valid) begin
        state      <= EXEC;
        last_grant <= gnt;
        id         <= gnt;
        alu_a      <= gnt ? req_a1 : req_a0;
        alu_b      <= gnt ? req_b1 : req_b0;
        alu_op     <= gnt ? req_op1 : req_op0;
      end
    end else if (state == EXEC) begin
      state    <= RESP;
      rsp_data <= alu_out;
      rsp_err  <= alu_op > LAST;
    end else if (state == RESP) begin
      if (rsp_ready[id]) state <= IDLE;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a0, req_b0, req_a1, req_b1, alu_a, alu_b, alu_out, rsp_data;
  logic [3:0] req_op0, req_op1, alu_op;
  logic       rsp_err;
  int         checks = 0;
  int         failures = 0;

  alu_arbiter #(.LAST_OP(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // shared ALU: 0 add, 1 sub, 2 and, 3 or, 4 pass a, 5 xor, others yield zero
  always_comb
    case (alu_op)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a & alu_b;
      4'd3:    alu_out = alu_a | alu_b;
      4'd4:    alu_out = alu_a;
      4'd5:    alu_out = alu_a ^ alu_b;
      default: alu_out = 8'h00;
    endcase

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    if (id) begin
      req_a1 = a; req_b1 = b; req_op1 = op;
    end else begin
      req_a0 = a; req_b0 = b; req_op0 = op;
    end
  endtask

  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic [7:0] exp, input logic err);
    logic [1:0] oh;
    oh = id ? 2'b10 : 2'b01;
    set_req(id, a, b, op);
    req_valid = oh;
    rsp_ready = 2'b11;
    #1;
    chk("op_req_ready", 32'(req_ready), 32'(oh));
    step();
    req_valid = 2'b00;
    chk("op_alu_a", 32'(alu_a), 32'(a));
    chk("op_alu_op", 32'(alu_op), 32'(op));
    chk("op_exec_rsp_valid", 32'(rsp_valid), 32'(0));
    step();
    chk("op_rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("op_rsp_data", 32'(rsp_data), 32'(exp));
    chk("op_rsp_err", 32'(rsp_err), 32'(err));
    step();
    chk("op_done_rsp_valid", 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_a0 = 8'h0; req_b0 = 8'h0; req_op0 = 4'h0;
    req_a1 = 8'h0; req_b1 = 8'h0; req_op1 = 4'h0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_alu_op", 32'(alu_op), 32'(0));
    req_valid = 2'b00;
    step();
    rst_n = 1'b1;
    run_op(1'b0, 8'h05, 8'h03, 4'd0, 8'h08, 1'b0);
    run_op(1'b1, 8'h02, 8'h05, 4'd1, 8'hFD, 1'b0);
    run_op(1'b0, 8'hFF, 8'h01, 4'd0, 8'h00, 1'b0);
    run_op(1'b1, 8'h03, 8'h04, 4'd9, 8'h00, 1'b1);
    run_op(1'b0, 8'h01, 8'h02, 4'd4, 8'h01, 1'b0);
    chk("idle_alu_a_hold", 32'(alu_a), 32'(8'h01));
    // contention right after reset: 0,1,0,1
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_req(1'b0, 8'h0A, 8'h14, 4'd0);
    set_req(1'b1, 8'h30, 8'h10, 4'd1);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_req_ready", 32'(req_ready), 32'(k % 2 ? 2'b10 : 2'b01));
      step();
      step();
      chk("cont_rsp_valid", 32'(rsp_valid), 32'(k % 2 ? 2'b10 : 2'b01));
      chk("cont_rsp_data", 32'(rsp_data), 32'(k % 2 ? 8'h20 : 8'h1E));
      step();
    end
    // back-pressure with requester 1 waiting and a non-owner ready in the middle
    set_req(1'b0, 8'h11, 8'h22, 4'd3);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    #1;
    chk("bp_req_ready", 32'(req_ready), 32'(2'b01));
    step();
    req_valid = 2'b11;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(2'b01));
      chk("bp_rsp_data", 32'(rsp_data), 32'(8'h33));
      chk("bp_req_ready", 32'(req_ready), 32'(0));
      if (i == 2) rsp_ready = 2'b10;
      step();
    end
    rsp_ready = 2'b01;
    step();
    chk("bp_done_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("bp_next_grant", 32'(req_ready), 32'(2'b10));
    req_valid = 2'b00;
    step();
    // reset during EXEC
    set_req(1'b0, 8'h07, 8'h01, 4'd0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_alu_a", 32'(alu_a), 32'(0));
    chk("rst_exec_rsp_data", 32'(rsp_data), 32'(0));
    rst_n = 1'b1;
    step();
    step();
    chk("rst_exec_no_stale", 32'(rsp_valid), 32'(0));
    // reset during RESP
    set_req(1'b1, 8'h09, 8'h02, 4'd9);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    step();
    req_valid = 2'b00;
    step();
    chk("resp_pre_rst_valid", 32'(rsp_valid), 32'(2'b10));
    chk("resp_pre_rst_err", 32'(rsp_err), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_resp_err", 32'(rsp_err), 32'(0));
    chk("rst_resp_alu_op", 32'(alu_op), 32'(0));
    rst_n = 1'b1;
    step();
    chk("rst_resp_no_stale", 32'(rsp_valid), 32'(0));
    req_valid = 2'b11;
    #1;
    chk("rst_tie_grant0", 32'(req_ready), 32'(2'b01));
    req_valid = 2'b00;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: LAST_OP, default 5, highest legal ALU opcode; opcodes above it are flagged illegal.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester request accepted this cycle.
REQ-006 req_a0, req_b0 / req_a1, req_b1  input  8 each  operands per requester.
REQ-007 req_op0 / req_op1  input  4 each  ALU opcode per requester.
REQ-008 alu_a, alu_b  output  8 each  operands to shared ALU; alu_op  output  4  opcode to shared ALU.
REQ-009 alu_out  input  8  combinational result from shared ALU.
REQ-010 rsp_valid  output  2  per-requester response valid.
REQ-011 rsp_ready  input  2  per-requester response accept.
REQ-012 rsp_data  output  8  result, shared by both response channels; rsp_err  output  1  illegal-opcode flag.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; exactly one operation in flight at any time.
REQ-014 IDLE: if any req_valid bit set, grant one requester, assert its req_ready combinationally in that cycle, latch its operands/opcode/id, go EXEC.
REQ-015 req_ready SHALL be one-hot or zero, asserted only in IDLE, only for the granted requester with req_valid high.
REQ-016 Arbitration: round-robin; last_grant register; when both valid, grant the requester not granted last; single valid requester always granted.
REQ-017 last_grant updates only on an actual grant.
REQ-018 EXEC (one cycle): drive alu_a/alu_b/alu_op from latched values; capture alu_out into result register; capture rsp_err = (latched op > LAST_OP); go RESP.
REQ-019 Illegal opcode: still issued to ALU; rsp_data = captured alu_out (zero for current ALU), rsp_err = 1.
REQ-020 Outside EXEC, alu_a, alu_b, alu_op hold the last latched values (no toggling when idle).
REQ-021 RESP: assert rsp_valid bit of latched id only; rsp_data/rsp_err stable until handshake.
REQ-022 Response completes when rsp_valid[i] and rsp_ready[i] both high at a clock edge; then go IDLE.
REQ-023 rsp_ready for the non-owner is ignored; rsp_ready high before RESP has no effect.
REQ-024 Latency: grant at edge N, result captured at N+1, rsp_valid high from N+1 to handshake; minimum 3 cycles per op, back-to-back throughput 1 op per 3 cycles.
REQ-025 New requests arriving during EXEC/RESP wait; req_valid changes while not ready have no effect on state.
REQ-026 Arithmetic: 8-bit, wrap-around per ALU; arbiter does no arithmetic on data.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, last_grant = 1 (requester 0 wins first tie), req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, alu_a = alu_b = 0, alu_op = 0.
REQ-028 Reset mid-operation discards the in-flight op; no response is produced for it after release.
REQ-029 First grant possible in the first cycle after rst_n deasserts.

Verification
REQ-030 Single op: req0 a=0x05 b=0x03 op=0 -> rsp_valid=01, rsp_data=0x08, rsp_err=0, 3 cycles with rsp_ready held high.
REQ-031 Wrap: req1 a=0x02 b=0x05 op=1 -> rsp_valid=10, rsp_data=0xFD; a=0xFF b=0x01 op=0 -> 0x00.
REQ-032 Contention: both valid continuously, after reset -> grant order 0,1,0,1; each response on matching rsp_valid bit with correct data.
REQ-033 Back-pressure: rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready stays 00, no new grant until handshake.
REQ-034 Illegal op: op=9 -> rsp_data=0x00, rsp_err=1; op=4 a=0x01 b=0x02 -> rsp_data=0x01, rsp_err=0.
REQ-035 Reset in EXEC/RESP: rst_n pulsed low -> all outputs zero immediately, no stale rsp_valid after release, next tie granted to requester 0.
